// File: rtl/div_pkg.sv
// Shared definitions for the restoring divider.
package div_pkg;

    localparam int DIV_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step.
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] pr,
    input  logic             msb_in,
    input  logic [WIDTH-1:0] rb,
    output logic [WIDTH-1:0] pr_next,
    output logic             qbit
);

    logic [WIDTH:0] t;
    logic [WIDTH:0] diff;

    always_comb begin
        t       = {pr, msb_in};
        diff    = t - {1'b0, rb};
        qbit    = (t >= {1'b0, rb});
        pr_next = qbit ? diff[WIDTH-1:0] : t[WIDTH-1:0];
    end

endmodule

// File: rtl/div.sv
// Sequential restoring divider: one quotient bit per clock,
// with busy/done/divide-by-zero status.
module div
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             busy,
    output logic             done,
    output logic             dz
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state;
    state_t           state_n;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic [WIDTH-1:0] pr;
    logic [WIDTH-1:0] pr_n;
    logic [CW-1:0]    count;
    logic             qb;
    logic             last;
    logic             accept;
    logic             bzero;

    assign last   = (count == CW'(WIDTH - 1));
    assign accept = ld && (state == IDLE || state == FIN);
    assign bzero  = (b == '0);
    assign busy   = (state == RUN);

    div_step #(.WIDTH(WIDTH)) u_step (
        .pr      (pr),
        .msb_in  (ra[WIDTH-1]),
        .rb      (rb),
        .pr_next (pr_n),
        .qbit    (qb)
    );

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE, FIN: if (ld) state_n = bzero ? FIN : RUN;
            RUN:       if (last) state_n = FIN;
            default:   state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    // ra doubles as the quotient shift register while running
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ra    <= '0;
            rb    <= '0;
            pr    <= '0;
            count <= '0;
            q     <= '0;
            r     <= '0;
            done  <= 1'b0;
            dz    <= 1'b0;
        end else if (accept) begin
            ra    <= a;
            rb    <= b;
            pr    <= '0;
            count <= '0;
            done  <= bzero;
            dz    <= bzero;
            if (bzero) begin
                q <= '1;
                r <= a;
            end
        end else if (state == RUN) begin
            ra    <= {ra[WIDTH-2:0], qb};
            pr    <= pr_n;
            count <= count + CW'(1);
            if (last) begin
                q    <= {ra[WIDTH-2:0], qb};
                r    <= pr_n;
                done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_div.sv
// Directed bench for the restoring divider.
module tb_div;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ld  = 1'b0;
    logic [3:0] a   = '0;
    logic [3:0] b   = '0;
    logic [3:0] q;
    logic [3:0] r;
    logic       busy;
    logic       done;
    logic       dz;

    int vectors = 0;
    int errs    = 0;

    always #5 clk = ~clk;

    div #(.WIDTH(4)) dut (
        .clk  (clk),
        .rst  (rst),
        .ld   (ld),
        .a    (a),
        .b    (b),
        .q    (q),
        .r    (r),
        .busy (busy),
        .done (done),
        .dz   (dz)
    );

    task automatic chk(input string tag, input int got, input int exp);
        vectors++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // drive a one-cycle load; returns #1 after the load edge
    task automatic load(input logic [3:0] x, input logic [3:0] y);
        @(negedge clk);
        a  = x;
        b  = y;
        ld = 1'b1;
        @(posedge clk);
        #1;
        ld = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            n = i;
            if (done) break;
        end
    endtask

    task automatic run(input string tag, input logic [3:0] x,
                       input logic [3:0] y, input int eq, input int er);
        int n;
        load(x, y);
        chk({tag, "_busy0"}, busy, 1);
        chk({tag, "_done0"}, done, 0);
        wait_done(n);
        chk({tag, "_lat"}, n, 4);
        chk({tag, "_q"}, q, eq);
        chk({tag, "_r"}, r, er);
        chk({tag, "_dz"}, dz, 0);
        chk({tag, "_busy1"}, busy, 0);
    endtask

    initial begin
        int n;
        int sawbusy;
        int x;
        int y;

        #12;
        chk("rst_q", q, 0);
        chk("rst_r", r, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_dz", dz, 0);
        @(negedge clk);
        rst = 1'b1;

        run("d13_11", 4'd13, 4'd11, 1, 2);
        run("d9_6", 4'd9, 4'd6, 1, 3);
        #100;
        chk("hold_q", q, 1);
        chk("hold_r", r, 3);
        chk("hold_done", done, 1);

        run("d15_1", 4'd15, 4'd1, 15, 0);
        run("d3_7", 4'd3, 4'd7, 0, 3);
        run("d6_6", 4'd6, 4'd6, 1, 0);

        load(4'd5, 4'd0);
        chk("dz_dz", dz, 1);
        chk("dz_done", done, 1);
        chk("dz_q", q, 15);
        chk("dz_r", r, 5);
        sawbusy = busy;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            sawbusy |= busy;
        end
        chk("dz_nobusy", sawbusy, 0);
        chk("dz_hold", dz, 1);

        // a second load arriving mid-run must be ignored
        load(4'd13, 4'd11);
        @(posedge clk);
        @(negedge clk);
        a  = 4'd9;
        b  = 4'd6;
        ld = 1'b1;
        @(posedge clk);
        #1;
        ld = 1'b0;
        n  = 2;
        for (int i = 0; i < 20 && !done; i++) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("ign_lat", n, 4);
        chk("ign_q", q, 1);
        chk("ign_r", r, 2);

        load(4'd13, 4'd11);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("abort_q", q, 0);
        chk("abort_r", r, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        @(negedge clk);
        rst = 1'b1;
        run("post_rst", 4'd9, 4'd6, 1, 3);

        for (int k = 0; k < 8; k++) begin
            x = $urandom_range(0, 15);
            y = $urandom_range(1, 15);
            load(4'(x), 4'(y));
            wait_done(n);
            chk("rnd_lat", n, 4);
            chk("rnd_inv", int'(q) * y + int'(r), x);
            chk("rnd_rlt", int'(r) < y, 1);
            chk("rnd_q", q, x / y);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
